// File: rtl/binary_div_8_4_uni_if.sv
// Handshake/operand bus for the binary_div_8_4_uni restoring divider.
// master: the requester driving en/start/A/B; slave: the divider.
interface binary_div_8_4_uni_if #(
  parameter int N = 8,
  parameter int M = 4
);
  logic         en;
  logic         start;
  logic [N-1:0] A;
  logic [M-1:0] B;
  logic [N-1:0] Q;
  logic [M-1:0] R;
  logic         busy;
  logic         done;
  logic         div0;

  modport master (
    output en, start, A, B,
    input  Q, R, busy, done, div0
  );

  modport slave (
    input  en, start, A, B,
    output Q, R, busy, done, div0
  );
endinterface

// File: rtl/binary_div_8_4_uni.sv
// Iterative unsigned restoring divider: N-bit dividend / M-bit divisor,
// one quotient bit per enabled cycle, start/busy/done handshake.
// Optional macro BINARY_DIV_EARLY_EXIT_EN: when defined, operations with
// A < B finish immediately (Q=0, R=A) instead of running N iterations.
module binary_div_8_4_uni #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  binary_div_8_4_uni_if.slave    bus
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   dvd_q;    // dividend shifts out the top, quotient bits shift in the bottom
  logic [M-1:0]   div_q;
  logic [M-1:0]   rem_q;    // stored remainder is always < B, so M bits suffice
  logic [N-1:0]   q_q;
  logic [M-1:0]   r_q;
  logic           div0_q;

  logic [M:0]     t_w;      // M+1-bit trial partial remainder
  logic           qbit_w;
  logic [M-1:0]   diff_w;
  logic [M-1:0]   rem_nxt_w;
  logic [N-1:0]   quo_nxt_w;
  logic           b_zero_w;
  logic           early_w;

  assign t_w       = {rem_q, dvd_q[N-1]};
  assign qbit_w    = (t_w >= {1'b0, div_q});
  // When the subtraction is taken the result is < B, so the low M bits are exact.
  assign diff_w    = t_w[M-1:0] - div_q;
  assign rem_nxt_w = qbit_w ? diff_w : t_w[M-1:0];
  assign quo_nxt_w = {dvd_q[N-2:0], qbit_w};
  assign b_zero_w  = (bus.B == '0);

`ifdef BINARY_DIV_EARLY_EXIT_EN
  assign early_w = (bus.A < {{(N-M){1'b0}}, bus.B});
`else
  assign early_w = 1'b0;
`endif

  // State register; reset wins over enable
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; every transition is qualified by en
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.en && bus.start) state_d = (b_zero_w || early_w) ? DONE : CALC;
      CALC: if (bus.en && (cnt_q == '0)) state_d = DONE;
      DONE: if (bus.en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, one restoring step per CALC cycle, result write on entry to DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      dvd_q  <= '0;
      div_q  <= '0;
      rem_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      div0_q <= 1'b0;
    end else if (bus.en) begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            dvd_q <= bus.A;
            div_q <= bus.B;
            rem_q <= '0;
            cnt_q <= CW'(N - 1);
            if (b_zero_w) begin
              q_q    <= '1;
              r_q    <= '0;
              div0_q <= 1'b1;
            end else if (early_w) begin
              q_q    <= '0;
              r_q    <= bus.A[M-1:0];
              div0_q <= 1'b0;
            end
          end
        end
        CALC: begin
          dvd_q <= quo_nxt_w;
          rem_q <= rem_nxt_w;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            q_q    <= quo_nxt_w;
            r_q    <= rem_nxt_w;
            div0_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from state
  always_comb begin
    bus.busy = (state_q == CALC);
    bus.done = (state_q == DONE);
  end

  assign bus.Q    = q_q;
  assign bus.R    = r_q;
  assign bus.div0 = div0_q;

endmodule
